uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
- Byte FIFO plus transmit sequencer that sits directly upstream of uart_transmitter.
- Accepts bytes from application logic at clock rate and holds them in a DEPTH-entry buffer.
- Feeds bytes one at a time to the transmitter through its txStart/dataIn/tx_ready handshake, so producers never wait on the baud rate.

Parameters:
- DATA_WIDTH, 8, byte width; matches the transmitter's DATA_WIDTH.
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- START_TIMEOUT, 4096, maximum clk cycles to wait for tx_ready to fall after a start pulse.

Ports:
- clk  input  1  system clock; one clock domain.
- rstN  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request; one byte per cycle.
- wr_data  input  DATA_WIDTH  byte to enqueue.
- flush  input  1  synchronous FIFO clear.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is dropped.
- tx_timeout  output  1  sticky error flag; cleared only by reset.
- tx_ready  input  1  from the transmitter; high = idle and able to accept a byte.
- tx_start  output  1  to the transmitter's txStart; one-cycle registered pulse.
- tx_data  output  DATA_WIDTH  to the transmitter's dataIn.

Behaviour:
- Reset (rstN low, asynchronous), all values forced immediately:
  - count=0, empty=1, full=0, overflow=0, tx_timeout=0.
  - tx_start=0, tx_data=0, pointers=0, state=IDLE, timeout counter=0.
- Storage:
  - Circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits; both wrap DEPTH-1 -> 0.
  - full and empty are decoded from count, combinationally.
- Write path:
  - Write accepted at a clk edge when wr_en=1 and (full=0 or a pop occurs on the same edge).
  - An accepted write stores wr_data at wr_ptr and increments wr_ptr.
  - wr_en=1 while full=1 with no pop: byte dropped, overflow=1 for exactly the next cycle, nothing else changes.
- Count update per edge: write-only +1; pop-only -1; simultaneous write and pop leaves count unchanged.
- Pop / FSM, states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if empty=0 and tx_ready=1, on that edge: tx_data<=mem[rd_ptr], rd_ptr+1, count-1, tx_start<=1, timer<=0, go to WAIT_BUSY. Otherwise stay in IDLE.
  - WAIT_BUSY: tx_start<=0 (so the pulse is exactly 1 cycle wide); timer increments.
    - tx_ready=0 -> WAIT_DONE.
    - timer reaches START_TIMEOUT-1 with tx_ready still 1 -> tx_timeout<=1, go to IDLE; that byte is treated as consumed and is not resent.
  - WAIT_DONE: stay until tx_ready=1, then go to IDLE. The next pop can occur on the cycle after returning to IDLE, giving a minimum 1 idle cycle between frames.
- Latency: a byte written into an empty FIFO while the transmitter is idle gives tx_start=1 two cycles after the wr_en edge.
- tx_data holds its value from a pop until the next pop.
- Flush:
  - flush=1: pointers and count go to 0 on that edge; a wr_en in the same cycle is ignored.
  - In-flight transfer: FSM state, tx_data and tx_start are unaffected; a byte already popped completes normally.
  - No pop occurs on a flush edge.
- Reset mid-frame: the buffer returns to IDLE and empty; the transmitter is reset by the same rstN.

Test Plan:
- Write 0x41, 0x42, 0x43 with the transmitter model idle (tx_ready drops 3 cycles after tx_start, rises 100 cycles later) -> three single-cycle tx_start pulses with tx_data 0x41, 0x42, 0x43 in order; count returns to 0 and empty=1.
- Write 17 bytes 0x00..0x10 back-to-back with tx_ready=0 and DEPTH=16 -> count=16, full=1, overflow pulses once on the 17th write. Then set tx_ready=1: 0x00..0x0F are transmitted and 0x10 is never sent.
- Full FIFO, tx_ready=1, wr_en=1 with 0xAA on the pop edge -> write accepted, count stays 16, overflow=0; 0xAA is the last byte sent.
- Write 0x55 and hold tx_ready=1 permanently -> tx_start pulses, tx_timeout=1 after 4096 cycles in WAIT_BUSY, FSM returns to IDLE; flag stays 1 until rstN.
- Pop 0x10, then assert flush while in WAIT_DONE with 5 bytes queued -> 0x10 completes, count=0, no further tx_start.
- Deassert rstN asynchronously mid-WAIT_DONE with count=3 -> all outputs go to reset values before the next clk edge.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding uart_transmitter one byte at a time over its start/ready handshake.
// Producers write at clock rate; the sequencer paces pops to the transmitter's frame rate.
module uart_tx_buffer #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int START_TIMEOUT = 4096
) (
   input  logic                       clk,
   input  logic                       rstN,
   input  logic                       wr_en,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic                       flush,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       tx_timeout,
   input  logic                       tx_ready,
   output logic                       tx_start,
   output logic [DATA_WIDTH-1:0]      tx_data,
   output logic [1:0]                 dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(START_TIMEOUT) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);

   // Handshake: tx_ready high means the transmitter is idle; a one-cycle
   // tx_start with tx_data hands it a byte, and it answers by dropping
   // tx_ready for the frame and raising it again when the frame is done.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t                state, next_state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [TW-1:0]         timer;
   logic                  pop, timer_clr, timer_inc, set_timeout;
   logic                  wr_accept, wr_drop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign dbg_state = state;

   // A full FIFO still takes a write on the edge that frees a slot.
   assign wr_accept = wr_en && !flush && (!full || pop);
   assign wr_drop   = wr_en && !flush && full && !pop;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state  = state;
      pop         = 1'b0;
      timer_clr   = 1'b0;
      timer_inc   = 1'b0;
      set_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (!flush && !empty && tx_ready) begin
               pop        = 1'b1;
               timer_clr  = 1'b1;
               next_state = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!tx_ready) begin
               next_state = WAIT_DONE;
            end else if (timer == TIMER_LAST) begin
               // Transmitter never acknowledged; the byte is dropped, not resent.
               set_timeout = 1'b1;
               next_state  = IDLE;
            end else begin
               timer_inc = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (tx_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         timer      <= '0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         tx_timeout <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         tx_start <= pop;
         overflow <= wr_drop;
         if (pop)         tx_data    <= mem[rd_ptr];
         if (set_timeout) tx_timeout <= 1'b1;
         if (timer_clr)   timer      <= '0;
         else if (timer_inc) timer   <= timer + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)       rd_ptr <= rd_ptr + AW'(1);
         case ({wr_accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage has no reset; occupancy is tracked entirely by count and pointers.
   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer: vector table, directed corner sequences and a random
// run checked cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_tx_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int T     = 4096;
   localparam int CW    = $clog2(DEPTH) + 1;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic          wr_en = 1'b0;
   logic          flush = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          man_ready = 1'b1;
   logic          xm_ready = 1'b1;
   int            xm_mode = 0;
   logic          tx_ready;
   logic          full, empty, overflow, tx_timeout, tx_start;
   logic [CW-1:0] count;
   logic [DW-1:0] tx_data;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   assign tx_ready = (xm_mode == 1) ? xm_ready : man_ready;

   uart_tx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .START_TIMEOUT(T)) dut (
      .clk(clk), .rstN(rstN), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .tx_timeout(tx_timeout), .tx_ready(tx_ready), .tx_start(tx_start),
      .tx_data(tx_data), .dbg_state(dbg_state)
   );

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- transmitter model ----------------
   // Drops ready drop_d cycles after seeing a start, raises it busy_len cycles later.
   int drop_d = 3, busy_len = 100, xm_cnt = 0;
   bit rnd_delays = 0, xm_active = 0;

   always @(negedge clk) begin
      if (!rstN) begin
         xm_active = 0;
         xm_ready  = 1'b1;
      end else if (xm_mode == 1) begin
         if (xm_active) begin
            xm_cnt++;
            if (xm_cnt == drop_d) xm_ready = 1'b0;
            if (xm_cnt == drop_d + busy_len) begin
               xm_ready  = 1'b1;
               xm_active = 0;
            end
         end else if (tx_start) begin
            xm_active = 1;
            xm_cnt    = 0;
            if (rnd_delays) begin
               drop_d   = $urandom_range(1, 6);
               busy_len = $urandom_range(1, 20);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // The FIFO is a queue; the link is idle, started (awaiting ready low) or busy.
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] exp_q[$];
   int            m_link = 0;
   int            m_timer = 0;
   logic          m_start = 0, m_ovf = 0, m_to = 0;
   logic [DW-1:0] m_data = '0;

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         m_q.delete();
         exp_q.delete();
         m_link = 0; m_timer = 0;
         m_start = 0; m_ovf = 0; m_to = 0; m_data = '0;
      end else begin
         bit do_pop;
         logic [DW-1:0] b;
         do_pop  = (m_link == 0) && (m_q.size() > 0) && tx_ready && !flush;
         m_start = 0;
         m_ovf   = 0;
         if (flush) begin
            m_q.delete();
         end else begin
            if (do_pop) begin
               b = m_q.pop_front();
               exp_q.push_back(b);
               m_data  = b;
               m_start = 1;
            end
            if (wr_en) begin
               if (m_q.size() < DEPTH) m_q.push_back(wr_data);
               else m_ovf = 1;
            end
         end
         case (m_link)
            0: if (do_pop) begin m_link = 1; m_timer = 0; end
            1: begin
               if (!tx_ready) m_link = 2;
               else if (m_timer == T - 1) begin m_to = 1; m_link = 0; end
               else m_timer++;
            end
            default: if (tx_ready) m_link = 0;
         endcase
      end
   end

   // ---------------- scoreboard / cycle checker ----------------
   logic [DW-1:0] sent_q[$];
   int            start_cnt = 0;

   always @(negedge clk) begin
      if (rstN) begin
         check("count",      count,      m_q.size());
         check("full",       full,       m_q.size() == DEPTH);
         check("empty",      empty,      m_q.size() == 0);
         check("overflow",   overflow,   m_ovf);
         check("tx_start",   tx_start,   m_start);
         check("tx_data",    tx_data,    m_data);
         check("tx_timeout", tx_timeout, m_to);
         if (tx_start) begin
            sent_q.push_back(tx_data);
            start_cnt++;
            if (exp_q.size() == 0) check("sb_unexpected_start", 1, 0);
            else check("sb_byte", tx_data, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      rstN = 1'b0; wr_en = 1'b0; flush = 1'b0; man_ready = 1'b1;
      xm_mode = 0; rnd_delays = 0;
      repeat (2) @(negedge clk);
      sent_q.delete();
      start_cnt = 0;
      rstN = 1'b1;
   endtask

   task automatic write_byte(input logic [DW-1:0] d);
      wr_en = 1'b1; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic run_until_idle(input int budget, input string name);
      int n = 0;
      while (!(empty && dbg_state == 2'd0 && tx_ready) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_bound"}, n < budget, 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          wr_en;
      logic [DW-1:0] wr_data;
      logic          flush;
      logic          rdy;
      int            e_count;
      logic          e_full, e_empty, e_ovf, e_start;
      logic [DW-1:0] e_data;
   } vec_t;

   vec_t vecs[14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04};
      vecs[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04};
      vecs[8]  = '{1'b1, 8'h06, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h06};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_timeout", tx_timeout, 0);
      apply_reset();

      // table-driven vectors, transmitter ready driven directly
      for (int i = 0; i < 14; i++) begin
         wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data;
         flush = vecs[i].flush; man_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
         check($sformatf("vec%0d_full", i), full, vecs[i].e_full);
         check($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
         check($sformatf("vec%0d_overflow", i), overflow, vecs[i].e_ovf);
         check($sformatf("vec%0d_tx_start", i), tx_start, vecs[i].e_start);
         check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_data);
      end
      wr_en = 1'b0; flush = 1'b0;

      // three bytes to an idle transmitter
      apply_reset();
      xm_mode = 1; drop_d = 3; busy_len = 100;
      wr_en = 1'b1; wr_data = 8'h41;
      @(negedge clk);
      check("lat_first_edge_start", tx_start, 0);
      wr_data = 8'h42;
      @(negedge clk);
      check("lat_start", tx_start, 1);
      check("lat_data", tx_data, 8'h41);
      wr_data = 8'h43;
      @(negedge clk);
      wr_en = 1'b0;
      run_until_idle(1000, "abc");
      check("abc_sent_n", sent_q.size(), 3);
      check("abc_pulse_cycles", start_cnt, 3);
      if (sent_q.size() == 3) begin
         check("abc_b0", sent_q[0], 8'h41);
         check("abc_b1", sent_q[1], 8'h42);
         check("abc_b2", sent_q[2], 8'h43);
      end
      check("abc_count", count, 0);
      check("abc_empty", empty, 1);

      // fill to overflow, then a write on the pop edge of a full FIFO
      apply_reset();
      man_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1; wr_data = DW'(i);
         @(negedge clk);
         if (overflow) n++;
      end
      check("fill_ovf_on_17th", overflow, 1);
      wr_en = 1'b0;
      @(negedge clk);
      check("fill_ovf_one_cycle", overflow, 0);
      check("fill_ovf_pulses", n, 1);
      check("fill_count", count, 16);
      check("fill_full", full, 1);
      wr_en = 1'b1; wr_data = 8'hAA;
      xm_mode = 1; drop_d = 2; busy_len = 4;
      @(negedge clk);
      wr_en = 1'b0;
      check("popwr_count", count, 16);
      check("popwr_overflow", overflow, 0);
      check("popwr_start", tx_start, 1);
      run_until_idle(2000, "popwr");
      check("popwr_sent_n", sent_q.size(), 17);
      if (sent_q.size() == 17) begin
         for (int i = 0; i < 16; i++) check($sformatf("popwr_b%0d", i), sent_q[i], i);
         check("popwr_last_aa", sent_q[16], 8'hAA);
      end

      // start timeout with ready stuck high
      apply_reset();
      man_ready = 1'b1;
      write_byte(8'h55);
      n = 0;
      while (!tx_start && n < 10) begin @(negedge clk); n++; end
      check("to_start_seen", tx_start, 1);
      check("to_start_data", tx_data, 8'h55);
      n = 0;
      while (!tx_timeout && n < T + 10) begin @(negedge clk); n++; end
      check("to_cycles", n, T);
      check("to_state_idle", dbg_state, 0);
      write_byte(8'h66);
      repeat (20) @(negedge clk);
      check("to_sticky", tx_timeout, 1);
      check("to_next_sent", sent_q.size(), 2);
      apply_reset();
      check("to_cleared", tx_timeout, 0);

      // flush while a frame is in flight
      man_ready = 1'b1;
      write_byte(8'h10);
      @(negedge clk);
      check("fl_start", tx_start, 1);
      man_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = DW'(8'h20 + i);
         @(negedge clk);
      end
      check("fl_queued", count, 5);
      check("fl_wait_done", dbg_state, 2);
      wr_data = 8'h99; flush = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; flush = 1'b0;
      check("fl_count", count, 0);
      check("fl_empty", empty, 1);
      check("fl_state_kept", dbg_state, 2);
      check("fl_data_kept", tx_data, 8'h10);
      man_ready = 1'b1;
      n = start_cnt;
      repeat (50) @(negedge clk);
      check("fl_no_more_start", start_cnt, n);
      check("fl_idle", dbg_state, 0);

      // asynchronous reset mid-frame
      apply_reset();
      man_ready = 1'b1;
      write_byte(8'h77);
      @(negedge clk);
      man_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = DW'(8'h30 + i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      check("ar_pre_count", count, 3);
      check("ar_pre_data", tx_data, 8'h77);
      #2 rstN = 1'b0;
      #1;
      check("ar_count", count, 0);
      check("ar_empty", empty, 1);
      check("ar_full", full, 0);
      check("ar_tx_data", tx_data, 0);
      check("ar_tx_start", tx_start, 0);
      check("ar_state", dbg_state, 0);
      @(negedge clk);
      rstN = 1'b1;

      // randomized traffic against the reference model
      apply_reset();
      xm_mode = 1; rnd_delays = 1; drop_d = 2; busy_len = 5;
      for (int seg = 0; seg < 4; seg++) begin
         int pct;
         pct = (seg == 0) ? 10 : (seg == 1) ? 60 : (seg == 2) ? 95 : 30;
         for (int c = 0; c < 800; c++) begin
            wr_en   = ($urandom_range(0, 99) < pct);
            wr_data = DW'($urandom);
            flush   = ($urandom_range(0, 299) == 0);
            @(negedge clk);
         end
      end
      wr_en = 1'b0; flush = 1'b0;
      run_until_idle(3000, "rnd");
      check("rnd_sb_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
